// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: FSM states,
// data-bit encoding and the oversample baud divisor.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    function automatic logic [3:0] data_bits_count(input logic [1:0] code);
        case (code)
            DBITS_5: return 4'd5;
            DBITS_6: return 4'd6;
            DBITS_7: return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

    // Clocks per oversample tick, truncated toward zero.
    function automatic int div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data; full/empty come
// from pointers carrying one extra wrap bit.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          wr_en;
    logic          rd_en;

    // A write while full is dropped even when a pop frees a slot this cycle.
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;

endmodule

// File: rtl/uart_tx_path.sv
// UART transmitter: byte FIFO feeding a start/data/stop serialiser timed by
// a 16x oversample tick divider. Frame format is latched per popped byte.
module uart_tx_path
    import uart_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 19200,
    parameter int FIFO_AW = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [7:0]       i_wdata,
    input  logic [1:0]       i_data_bits,
    input  logic             i_stop2,
    output logic             o_tx,
    output logic             o_tx_full,
    output logic             o_tx_empty,
    output logic [FIFO_AW:0] o_level,
    output logic             o_busy
);

    localparam int DIV   = div(CLK_HZ, BAUD);
    localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [4:0] TICKS_BIT_LAST   = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] TICKS_STOP2_LAST = 5'(2 * OVERSAMPLE - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_path: CLK_HZ/(BAUD*16) must be at least 2");
        end
    endgenerate

    tx_state_e        state;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [4:0]       tick_cnt;
    logic [4:0]       phase_last;
    logic             phase_end;
    logic [2:0]       bit_idx;
    logic [2:0]       last_idx;
    logic             stop2_q;
    logic [7:0]       shift;
    logic             fifo_rd;
    logic [7:0]       fifo_rdata;

    uart_sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .wr    (i_wr),
        .wdata (i_wdata),
        .rd    (fifo_rd),
        .rdata (fifo_rdata),
        .full  (o_tx_full),
        .empty (o_tx_empty),
        .level (o_level)
    );

    assign fifo_rd    = (state == ST_IDLE) && !o_tx_empty;
    assign tick       = (div_cnt == DIV_LAST);
    assign phase_last = (state == ST_STOP && stop2_q) ? TICKS_STOP2_LAST : TICKS_BIT_LAST;
    assign phase_end  = tick && (tick_cnt == phase_last);
    assign o_busy     = (state != ST_IDLE);

    // Divider and tick count restart on the pop so the start bit is full length.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            if (fifo_rd || tick) div_cnt <= '0;
            else                 div_cnt <= div_cnt + DIV_W'(1);

            if (fifo_rd)        tick_cnt <= '0;
            else if (phase_end) tick_cnt <= '0;
            else if (tick)      tick_cnt <= tick_cnt + 5'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            last_idx <= '0;
            stop2_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_rd) begin
                        state    <= ST_START;
                        last_idx <= 3'(data_bits_count(i_data_bits) - 4'd1);
                        stop2_q  <= i_stop2;
                    end
                end
                ST_START: begin
                    if (phase_end) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (phase_end) begin
                        if (bit_idx == last_idx) state <= ST_STOP;
                        else                     bit_idx <= bit_idx + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (phase_end) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (fifo_rd)                            shift <= fifo_rdata;
        else if (state == ST_DATA && phase_end) shift <= shift >> 1;
    end

    // Line register lags the state by one clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tx <= 1'b1;
        end else begin
            case (state)
                ST_START: o_tx <= 1'b0;
                ST_DATA:  o_tx <= shift[0];
                default:  o_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_path.sv
// Directed bench for uart_tx_path at DIV=10 (160 clocks per bit).
module tb_uart_tx_path;

    localparam int BIT_CLKS = 160;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_wr;
    logic [7:0] i_wdata;
    logic [1:0] i_data_bits;
    logic       i_stop2;
    logic       o_tx;
    logic       o_tx_full;
    logic       o_tx_empty;
    logic [4:0] o_level;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_path #(
        .CLK_HZ  (3_072_000),
        .BAUD    (19200),
        .FIFO_AW (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr        (i_wr),
        .i_wdata     (i_wdata),
        .i_data_bits (i_data_bits),
        .i_stop2     (i_stop2),
        .o_tx        (o_tx),
        .o_tx_full   (o_tx_full),
        .o_tx_empty  (o_tx_empty),
        .o_level     (o_level),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        if (n > 0) begin
            repeat (n) @(posedge i_clk);
            #1;
        end
    endtask

    // Called 'elapsed' clocks after the edge where the FSM entered START.
    task automatic expect_frame(input string tag, input logic [7:0] b, input int nb,
                                input bit s2, input int elapsed);
        int   nunits;
        int   t;
        logic exp;
        nunits = 1 + nb + (s2 ? 2 : 1);
        t = elapsed;
        for (int i = 0; i < nunits; i++) begin
            if (i == 0)       exp = 1'b0;
            else if (i <= nb) exp = b[i-1];
            else              exp = 1'b1;
            if (t < BIT_CLKS * i + 1) begin
                wait_clks(BIT_CLKS * i + 1 - t);
                t = BIT_CLKS * i + 1;
                check($sformatf("%s bit%0d first", tag, i), o_tx, exp);
            end
            wait_clks(BIT_CLKS * i + BIT_CLKS - 1 - t);
            t = BIT_CLKS * i + BIT_CLKS - 1;
            if (i == nunits - 1) check($sformatf("%s busy end-1", tag), o_busy, 1);
            wait_clks(1);
            t++;
            check($sformatf("%s bit%0d last", tag, i), o_tx, exp);
        end
        check($sformatf("%s busy end", tag), o_busy, 0);
    endtask

    logic [7:0] t6_bytes [6];
    int         lows;

    initial begin
        i_rst       = 1'b1;
        i_wr        = 1'b0;
        i_wdata     = 8'h00;
        i_data_bits = 2'b11;
        i_stop2     = 1'b0;
        t6_bytes    = '{8'hC3, 8'h3C, 8'hA5, 8'h5A, 8'h96, 8'h69};

        wait_clks(2);
        check("rst tx", o_tx, 1);
        check("rst full", o_tx_full, 0);
        check("rst empty", o_tx_empty, 1);
        check("rst level", o_level, 0);
        check("rst busy", o_busy, 0);
        i_rst = 1'b0;
        wait_clks(3);
        check("idle tx", o_tx, 1);
        check("idle busy", o_busy, 0);

        // 1: 0x55, 8 data bits, one stop
        i_data_bits = 2'b11; i_stop2 = 1'b0;
        i_wdata = 8'h55; i_wr = 1'b1;
        wait_clks(1);
        i_wr = 1'b0;
        check("t1 empty after wr", o_tx_empty, 0);
        check("t1 level after wr", o_level, 1);
        wait_clks(1);
        check("t1 empty after pop", o_tx_empty, 1);
        check("t1 busy start", o_busy, 1);
        check("t1 tx before line", o_tx, 1);
        expect_frame("t1", 8'h55, 8, 1'b0, 0);

        // 2: 0xFF, 5 data bits, two stops
        i_data_bits = 2'b00; i_stop2 = 1'b1;
        i_wdata = 8'hFF; i_wr = 1'b1;
        wait_clks(1);
        i_wr = 1'b0;
        wait_clks(1);
        expect_frame("t2", 8'hFF, 5, 1'b1, 0);
        wait_clks(50);
        check("t2 tx after", o_tx, 1);

        // 3: 18 back-to-back writes, last one dropped
        i_data_bits = 2'b11; i_stop2 = 1'b0;
        i_wr = 1'b1;
        for (int i = 0; i < 18; i++) begin
            i_wdata = 8'(i);
            wait_clks(1);
        end
        i_wr = 1'b0;
        check("t3 level full", o_level, 16);
        check("t3 full flag", o_tx_full, 1);
        check("t3 empty flag", o_tx_empty, 0);
        expect_frame("t3 f0", 8'h00, 8, 1'b0, 16);
        for (int k = 1; k <= 16; k++) begin
            wait_clks(1);
            check($sformatf("t3 gap%0d tx", k), o_tx, 1);
            check($sformatf("t3 gap%0d busy", k), o_busy, 1);
            if (k == 1) begin
                check("t3 level after pop", o_level, 15);
                check("t3 full after pop", o_tx_full, 0);
            end
            expect_frame($sformatf("t3 f%0d", k), 8'(k), 8, 1'b0, 0);
        end
        check("t3 drained empty", o_tx_empty, 1);
        check("t3 drained level", o_level, 0);
        wait_clks(2);
        check("t3 dropped not sent", o_busy, 0);

        // 5 + 6: config change mid-frame; write and pop in the same cycle at level 5
        i_data_bits = 2'b11; i_stop2 = 1'b0;
        i_wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_wdata = t6_bytes[i];
            wait_clks(1);
        end
        i_wr = 1'b0;
        check("t6 level queued", o_level, 5);
        i_data_bits = 2'b01;
        expect_frame("t5 f0 8bit", t6_bytes[0], 8, 1'b0, 4);
        check("t6 level before", o_level, 5);
        i_wdata = 8'hE7; i_wr = 1'b1;
        wait_clks(1);
        i_wr = 1'b0;
        check("t6 level same", o_level, 5);
        check("t6 busy", o_busy, 1);
        expect_frame("t5 f1 6bit", t6_bytes[1], 6, 1'b0, 0);
        for (int i = 2; i < 6; i++) begin
            wait_clks(1);
            expect_frame($sformatf("t6 f%0d", i), t6_bytes[i], 6, 1'b0, 0);
        end
        wait_clks(1);
        expect_frame("t6 written", 8'hE7, 6, 1'b0, 0);

        // 4: asynchronous reset mid-DATA with 3 bytes queued
        i_data_bits = 2'b11; i_stop2 = 1'b0;
        i_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_wdata = 8'(i * 8'h11);
            wait_clks(1);
        end
        i_wr = 1'b0;
        wait_clks(558);
        check("t4 busy mid", o_busy, 1);
        check("t4 tx low mid", o_tx, 0);
        check("t4 level mid", o_level, 3);
        #2;
        i_rst = 1'b1;
        #1;
        check("t4 rst tx", o_tx, 1);
        check("t4 rst empty", o_tx_empty, 1);
        check("t4 rst level", o_level, 0);
        check("t4 rst busy", o_busy, 0);
        wait_clks(3);
        i_rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 5000; i++) begin
            wait_clks(1);
            if (o_tx !== 1'b1 || o_busy !== 1'b0) lows++;
        end
        check("t4 line idle after rst", lows, 0);
        check("t4 empty after rst", o_tx_empty, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
